// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, step encodings and control word for the control sequencer
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'b0000,
    S_T0   = 4'b0111,
    S_T1   = 4'b1000,
    S_T2   = 4'b1001,
    S_T3   = 4'b1010,
    S_T4   = 4'b1011,
    S_T5   = 4'b1100,
    S_T6   = 4'b1101,
    S_T7   = 4'b1110,
    S_HALT = 4'b1111
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [2:0] {
    C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_ALU, C_ADDI
  } op_class_t;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, ram_we;
    logic ir_in, y_in, zlow_in, zhigh_in, zlow_out;
    logic gra, grb, grc, r_in, r_out, ba_out, c_out;
  } ctrl_t;

  // Unlisted opcodes fold into the nop class so they take the nop path.
  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_LD:                         return C_LD;
      OP_LDI:                        return C_LDI;
      OP_ST:                         return C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_ALU;
      OP_ADDI:                       return C_ADDI;
      OP_HALT:                       return C_HALT;
      default:                       return C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// rtl/ctrl_out_decode.sv - combinational control-word and alu_op decode from step and opcode
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [4:0]  opcode,
  output ctrl_t       ctrl,
  output logic [4:0]  alu_op
);

  op_class_t cls;

  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    cls    = classify(opcode);
    case (state)
      S_T0: begin
        ctrl.pc_out  = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.inc_pc  = 1'b1;
        ctrl.zlow_in = 1'b1;
        alu_op       = ALU_ADD;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        alu_op        = ALU_ADD;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        alu_op       = ALU_ADD;
      end
      S_T3: begin
        if (cls inside {C_LD, C_LDI, C_ST}) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (cls inside {C_ALU, C_ADDI}) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end
      end
      S_T4: begin
        if (cls == C_ALU) begin
          ctrl.grc   = 1'b1;
          ctrl.r_out = 1'b1;
        end else if (cls inside {C_LD, C_LDI, C_ST, C_ADDI}) begin
          ctrl.c_out = 1'b1;
        end
        ctrl.zlow_in  = (cls inside {C_LD, C_LDI, C_ST, C_ALU, C_ADDI});
        ctrl.zhigh_in = ctrl.zlow_in;
      end
      S_T5: begin
        if (cls inside {C_LD, C_ST}) begin
          ctrl.zlow_out = 1'b1;
          ctrl.mar_in   = 1'b1;
        end else if (cls inside {C_LDI, C_ALU, C_ADDI}) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
        end
      end
      S_T6: begin
        if (cls == C_LD) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (cls == C_ST) begin
          ctrl.gra    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.mdr_in = 1'b1;
        end
      end
      S_T7: begin
        if (cls == C_LD) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.r_in    = 1'b1;
        end else if (cls == C_ST) begin
          ctrl.ram_we = 1'b1;
        end
      end
      default: ;
    endcase
    // Execute steps: address/immediate arithmetic adds, register ALU ops pass the opcode through.
    if (state inside {S_T3, S_T4, S_T5, S_T6, S_T7}) begin
      if (cls inside {C_LD, C_LDI, C_ST, C_ADDI}) alu_op = ALU_ADD;
      else if (cls == C_ALU)                      alu_op = opcode;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute step sequencer with stop-at-boundary halt
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       stop,
  output logic       PCout, PCin, IncPC,
  output logic       MARin, MDRin, MDRout, Read, ramWE,
  output logic       IRin, Yin, ZLowIn, ZHighIn, ZLowout,
  output logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic [4:0] alu_op,
  output logic [3:0] t_state,
  output logic       run
);

  state_t    state_q, state_d;
  op_class_t cls;
  ctrl_t     ctrl;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Instruction-boundary steps honour stop; earlier steps ignore it.
  always_comb begin
    state_d = state_q;
    cls     = classify(opcode);
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (cls == C_HALT)     state_d = S_HALT;
        else if (cls == C_NOP) state_d = stop ? S_HALT : S_T0;
        else                   state_d = S_T4;
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (cls inside {C_LD, C_ST}) state_d = S_T6;
        else                         state_d = stop ? S_HALT : S_T0;
      end
      S_T6:   state_d = S_T7;
      S_T7:   state_d = stop ? S_HALT : S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  ctrl_out_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl),
    .alu_op (alu_op)
  );

  assign {PCout, PCin, IncPC}                   = {ctrl.pc_out, ctrl.pc_in, ctrl.inc_pc};
  assign {MARin, MDRin, MDRout, Read, ramWE}    = {ctrl.mar_in, ctrl.mdr_in, ctrl.mdr_out,
                                                   ctrl.read, ctrl.ram_we};
  assign {IRin, Yin, ZLowIn, ZHighIn, ZLowout}  = {ctrl.ir_in, ctrl.y_in, ctrl.zlow_in,
                                                   ctrl.zhigh_in, ctrl.zlow_out};
  assign {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = {ctrl.gra, ctrl.grb, ctrl.grc, ctrl.r_in,
                                                    ctrl.r_out, ctrl.ba_out, ctrl.c_out};
  assign t_state = state_q;
  assign run     = (state_q != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic       clk, clr, stop;
  logic [4:0] opcode;
  logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, ramWE;
  logic       IRin, Yin, ZLowIn, ZHighIn, ZLowout;
  logic       Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [4:0] alu_op;
  logic [3:0] t_state;
  logic       run;
  logic [19:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [19:0] PCO = 20'h80000, PCI = 20'h40000, INC = 20'h20000, MAR = 20'h10000;
  localparam logic [19:0] MDI = 20'h08000, MDO = 20'h04000, RD  = 20'h02000, WE  = 20'h01000;
  localparam logic [19:0] IRI = 20'h00800, YI  = 20'h00400, ZLI = 20'h00200, ZHI = 20'h00100;
  localparam logic [19:0] ZLO = 20'h00080, GA  = 20'h00040, GB  = 20'h00020, GC  = 20'h00010;
  localparam logic [19:0] RI  = 20'h00008, RO  = 20'h00004, BA  = 20'h00002, CO  = 20'h00001;
  localparam logic [19:0] NONE = 20'h00000;

  localparam logic [19:0] F0 = PCO | MAR | INC | ZLI;
  localparam logic [19:0] F1 = ZLO | PCI | RD | MDI;
  localparam logic [19:0] F2 = MDO | IRI;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .ramWE(ramWE),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .alu_op(alu_op), .t_state(t_state), .run(run)
  );

  assign ctl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, ramWE,
                IRin, Yin, ZLowIn, ZHighIn, ZLowout,
                Gra, Grb, Grc, Rin, Rout, BAout, Cout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag, input logic [3:0] st, input logic [19:0] c,
                            input logic chk_alu, input logic [4:0] alu);
    check({tag, " t_state"}, 32'(t_state), 32'(st));
    check({tag, " ctl"}, 32'(ctl), 32'(c));
    check({tag, " run"}, 32'(run), 32'(st != 4'b1111));
    if (chk_alu) check({tag, " alu_op"}, 32'(alu_op), 32'(alu));
    if (Rin || Rout) check({tag, " gr onehot"}, 32'($countones({Gra, Grb, Grc})), 32'd1);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; stop = 1'b0; opcode = 5'b00000;
    #1;
    check_step("reset", 4'b0000, NONE, 1'b1, 5'b00000);
    @(negedge clk); clr = 1'b0;
    check_step("reset release", 4'b0000, NONE, 1'b1, 5'b00000);

    // ld
    tick(); check_step("ld T0", 4'b0111, F0, 1'b1, 5'b00011);
    tick(); check_step("ld T1", 4'b1000, F1, 1'b0, 5'b0);
    tick(); check_step("ld T2", 4'b1001, F2, 1'b0, 5'b0);
    tick(); check_step("ld T3", 4'b1010, GB | BA | YI, 1'b1, 5'b00011);
    tick(); check_step("ld T4", 4'b1011, CO | ZLI | ZHI, 1'b1, 5'b00011);
    tick(); check_step("ld T5", 4'b1100, ZLO | MAR, 1'b1, 5'b00011);
    tick(); check_step("ld T6", 4'b1101, RD | MDI, 1'b1, 5'b00011);
    tick(); check_step("ld T7", 4'b1110, MDO | GA | RI, 1'b1, 5'b00011);

    // st
    tick(); check_step("st T0", 4'b0111, F0, 1'b1, 5'b00011); opcode = 5'b00010;
    tick(); check_step("st T1", 4'b1000, F1, 1'b0, 5'b0);
    tick(); check_step("st T2", 4'b1001, F2, 1'b0, 5'b0);
    tick(); check_step("st T3", 4'b1010, GB | BA | YI, 1'b1, 5'b00011);
    tick(); check_step("st T4", 4'b1011, CO | ZLI | ZHI, 1'b1, 5'b00011);
    tick(); check_step("st T5", 4'b1100, ZLO | MAR, 1'b1, 5'b00011);
    tick(); check_step("st T6", 4'b1101, GA | RO | MDI, 1'b1, 5'b00011);
    tick(); check_step("st T7", 4'b1110, WE, 1'b1, 5'b00011);

    // sub
    tick(); check_step("sub T0", 4'b0111, F0, 1'b1, 5'b00011); opcode = 5'b00100;
    tick(); check_step("sub T1", 4'b1000, F1, 1'b0, 5'b0);
    tick(); check_step("sub T2", 4'b1001, F2, 1'b0, 5'b0);
    tick(); check_step("sub T3", 4'b1010, GB | RO | YI, 1'b1, 5'b00100);
    tick(); check_step("sub T4", 4'b1011, GC | RO | ZLI | ZHI, 1'b1, 5'b00100);
    tick(); check_step("sub T5", 4'b1100, ZLO | GA | RI, 1'b1, 5'b00100);

    // addi
    tick(); check_step("addi T0", 4'b0111, F0, 1'b1, 5'b00011); opcode = 5'b01001;
    tick(); tick();
    tick(); check_step("addi T3", 4'b1010, GB | RO | YI, 1'b1, 5'b00011);
    tick(); check_step("addi T4", 4'b1011, CO | ZLI | ZHI, 1'b1, 5'b00011);
    tick(); check_step("addi T5", 4'b1100, ZLO | GA | RI, 1'b1, 5'b00011);

    // nop-like opcode 10101: four steps then back to T0
    tick(); check_step("unk T0", 4'b0111, F0, 1'b1, 5'b00011); opcode = 5'b10101;
    tick(); tick();
    tick(); check_step("unk T3", 4'b1010, NONE, 1'b0, 5'b0);

    // add with stop raised mid-instruction
    tick(); check_step("add T0", 4'b0111, F0, 1'b1, 5'b00011); opcode = 5'b00011;
    tick(); tick(); tick();
    tick(); check_step("add T4", 4'b1011, GC | RO | ZLI | ZHI, 1'b1, 5'b00011); stop = 1'b1;
    tick(); check_step("add T5 stop", 4'b1100, ZLO | GA | RI, 1'b1, 5'b00011);
    tick(); check_step("add halt", 4'b1111, NONE, 1'b1, 5'b00000);
    tick(); check_step("add halt hold", 4'b1111, NONE, 1'b1, 5'b00000);
    clr = 1'b1; stop = 1'b0; #1;
    check_step("clr from halt", 4'b0000, NONE, 1'b1, 5'b00000);
    @(negedge clk); clr = 1'b0;

    // ld aborted by clr during T6
    opcode = 5'b00000;
    tick(); check_step("ld2 T0", 4'b0111, F0, 1'b1, 5'b00011);
    for (int i = 0; i < 6; i++) tick();
    check_step("ld2 T6", 4'b1101, RD | MDI, 1'b1, 5'b00011);
    #2 clr = 1'b1; #1;
    check_step("ld2 clr async", 4'b0000, NONE, 1'b1, 5'b00000);
    tick(); check_step("ld2 clr held", 4'b0000, NONE, 1'b1, 5'b00000);
    clr = 1'b0;
    tick(); check_step("ld2 refetch T0", 4'b0111, F0, 1'b1, 5'b00011);

    // halt opcode
    opcode = 5'b11011;
    tick(); tick();
    tick(); check_step("halt T3", 4'b1010, NONE, 1'b0, 5'b0);
    for (int i = 0; i < 20; i++) begin
      tick(); check_step("halt hold", 4'b1111, NONE, 1'b1, 5'b00000);
    end
    clr = 1'b1; #1;
    check_step("halt clr", 4'b0000, NONE, 1'b1, 5'b00000);
    @(negedge clk); clr = 1'b0; opcode = 5'b11010;
    tick(); check_step("halt restart T0", 4'b0111, F0, 1'b1, 5'b00011);

    // nop with stop at the boundary
    stop = 1'b1;
    tick(); tick();
    tick(); check_step("nop T3", 4'b1010, NONE, 1'b0, 5'b0);
    tick(); check_step("nop stop halt", 4'b1111, NONE, 1'b1, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clk  in  1  single clock, all state changes on rising edge.
REQ-002 clr  in  1  reset, asynchronous and active-high.
REQ-003 opcode  in  5  the IR[31:27] instruction opcode, valid from the cycle after IRin.
REQ-004 stop  in  1  request to halt at the next instruction boundary.
REQ-005 PCout, PCin, IncPC  out  1 each  PC bus drive / PC load / ALU PC+1 select.
REQ-006 MARin, MDRin, MDRout, Read, ramWE  out  1 each  memory-interface controls.
REQ-007 IRin, Yin, ZLowIn, ZHighIn, ZLowout  out  1 each  register enables and bus drives.
REQ-008 Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and immediate controls.
REQ-009 alu_op  out  5  ALU operation code.
REQ-010 t_state  out  4  current step: RST=0000, T0..T7=0111..1110, HALT=1111.
REQ-011 run  out  1  high unless in HALT.

Function
REQ-012 All control outputs SHALL be combinational decodes of the registered state and opcode; no output may depend on stop.
REQ-013 Any control output not listed for a state SHALL be 0 in that state.
REQ-014 Opcode encodings SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01001, nop 11010, halt 11011; every other code SHALL execute as nop.
REQ-015 RST SHALL go unconditionally to T0 on the next edge.
REQ-016 Fetch: T0 asserts PCout, MARin, IncPC, ZLowIn; T1 asserts ZLowout, PCin, Read, MDRin; T2 asserts MDRout, IRin; T0->T1->T2->T3.
REQ-017 T3 decodes opcode: nop returns to T0 with no outputs asserted; halt goes to HALT.
REQ-018 ld: T3 Grb, BAout, Yin; T4 Cout, ZLowIn, ZHighIn; T5 ZLowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin; then T0.
REQ-019 ldi: T3 and T4 as ld; T5 ZLowout, Gra, Rin; then T0.
REQ-020 st: T3 through T5 as ld; T6 Gra, Rout, MDRin (Read=0); T7 ramWE; then T0.
REQ-021 add/sub/and/or: T3 Grb, Rout, Yin; T4 Grc, Rout, ZLowIn, ZHighIn; T5 ZLowout, Gra, Rin; then T0.
REQ-022 addi: T3 Grb, Rout, Yin; T4 Cout, ZLowIn, ZHighIn; T5 ZLowout, Gra, Rin; then T0.
REQ-023 alu_op SHALL equal 00011 (add) in T0 and for ld/ldi/st/addi; for add/sub/and/or it SHALL equal opcode; it SHALL be 00000 in RST and HALT.
REQ-024 The last step of an instruction (T3 for nop, T5 or T7 otherwise) SHALL go to HALT instead of T0 if stop=1 on that edge.
REQ-025 stop asserted mid-instruction SHALL NOT shorten the instruction; there is no path from HALT except clr.
REQ-026 HALT SHALL assert no control outputs and SHALL drive run=0.
REQ-027 Exactly one of Gra/Grb/Grc SHALL be high whenever Rin or Rout is high.

Reset
REQ-028 clr=1 SHALL force state RST immediately and asynchronously: all control outputs 0, alu_op=00000, t_state=0000, run=1.
REQ-029 clr asserted mid-instruction SHALL abort it; no Rin or ramWE pulse may follow the clr assertion.

Structure
REQ-030 The opcode constants, state encodings and the add alu_op code SHALL live in shared package cpu_ctrl_pkg.
REQ-031 The output decode SHALL be one combinational sub-module, ctrl_out_decode (inputs state and opcode); the state register and next-state logic SHALL stay in control_sequencer.

Verification
REQ-032 clr pulse, then opcode=00000 (ld) -> t_state 0000,0111..1110,0111; Rin only in T7; Read in T1 and T6; alu_op=00011 in T4.
REQ-033 opcode=00010 (st) -> ramWE high only in T7; MDRin with Rout in T6 with Read=0; Rin never high.
REQ-034 opcode=00100 (sub) -> alu_op=00100 in T4; Grc and Rout together in T4; Gra and Rin in T5; back to T0 after 6 cycles.
REQ-035 opcode=11011 (halt) -> HALT after T3; run=0; all outputs 0 for 20 cycles; clr returns to RST, then T0.
REQ-036 stop=1 raised during T4 of add -> instruction completes through T5, then HALT; opcode=10101 executes as a 4-cycle nop.
REQ-037 clr asserted during T6 of ld -> t_state=0000 within the same cycle; no Rin pulse; fetch restarts at T0.
